// File: rtl/ram_bus_master.sv
// RAM bus master: drives SRC and I/O frames on a shared 4-bit bus in lockstep
// with the RAM chips' free-running 8-clock frame counter.
module ram_bus_master (
  input  logic       clock,
  input  logic       reset,
  inout  wire  [3:0] data,
  output logic       sync,
  output logic       cmd_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_src,
  input  logic       req_chip,
  input  logic [1:0] req_reg,
  input  logic [3:0] req_char,
  input  logic [3:0] req_op,
  input  logic [3:0] req_wdata,
  output logic       done,
  output logic [3:0] rdata
);

  localparam int unsigned CYC_W = 3;
  localparam int unsigned NIB_W = 4;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(7);

  typedef enum logic [1:0] {IDLE, SRC, IO} state_t;

  typedef struct packed {
    logic             chip;
    logic [1:0]       reg_addr;
    logic [NIB_W-1:0] char_addr;
    logic [NIB_W-1:0] op;
    logic [NIB_W-1:0] wdata;
  } req_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] cycle, cycle_nx;
  req_t             cur, cur_nx;
  logic             accept;
  logic             drive, drive_nx;
  logic [NIB_W-1:0] dout, dout_nx;
  logic             cmd_n_nx;

  function automatic logic is_write(input logic [NIB_W-1:0] op);
    return (op == NIB_W'(0)) || (op[3:2] == 2'b01);
  endfunction

  function automatic logic is_read(input logic [NIB_W-1:0] op);
    return (op == NIB_W'(8)) || (op == NIB_W'(9)) || (op == NIB_W'(11));
  endfunction

  assign accept = req_valid && req_ready;
  assign data   = drive ? dout : 4'bz;

  // Next state plus one-cycle lookahead of the bus slots so every output is a flop.
  always_comb begin
    cycle_nx = cycle + CYC_W'(1);
    state_nx = state;
    cur_nx   = cur;
    drive_nx = 1'b0;
    dout_nx  = '0;
    cmd_n_nx = 1'b1;

    if (accept) begin
      cur_nx = '{chip: req_chip, reg_addr: req_reg, char_addr: req_char,
                 op: req_op, wdata: req_wdata};
    end

    case (state)
      IDLE:    if (accept) state_nx = req_src ? SRC : IO;
      SRC:     if (cycle == LAST_CYC) state_nx = IO;
      IO:      if (cycle == LAST_CYC) state_nx = accept ? (req_src ? SRC : IO) : IDLE;
      default: state_nx = IDLE;
    endcase

    if (state_nx == SRC && cycle_nx == CYC_W'(6)) begin
      cmd_n_nx = 1'b0;
      drive_nx = 1'b1;
      dout_nx  = {1'b0, cur_nx.chip, cur_nx.reg_addr};
    end else if (state_nx == SRC && cycle_nx == CYC_W'(7)) begin
      drive_nx = 1'b1;
      dout_nx  = cur_nx.char_addr;
    end else if (state_nx == IO && cycle_nx == CYC_W'(4)) begin
      cmd_n_nx = 1'b0;
      drive_nx = 1'b1;
      dout_nx  = cur_nx.op;
    end else if (state_nx == IO && cycle_nx == CYC_W'(6) && is_write(cur_nx.op)) begin
      drive_nx = 1'b1;
      dout_nx  = cur_nx.wdata;
    end
  end

  // State, captured request and registered bus/handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle     <= '0;
      state     <= IDLE;
      cur       <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      sync      <= 1'b0;
      cmd_n     <= 1'b1;
      req_ready <= 1'b0;
      drive     <= 1'b0;
      dout      <= '0;
    end else begin
      cycle     <= cycle_nx;
      state     <= state_nx;
      cur       <= cur_nx;
      done      <= (state == IO) && (cycle == LAST_CYC);
      if (state == IO && cycle == CYC_W'(6) && is_read(cur.op)) rdata <= data;
      sync      <= (cycle_nx == LAST_CYC);
      req_ready <= (state_nx == IDLE || state_nx == IO) && (cycle_nx == LAST_CYC);
      cmd_n     <= cmd_n_nx;
      drive     <= drive_nx;
      dout      <= dout_nx;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: two behavioural RAM chips (p0=0, p0=1) on a pulled-up
// bus, a done/rdata scoreboard and per-cycle bus rule checks.
module tb_ram_bus_master;

  logic       clock;
  logic       reset;
  tri1  [3:0] data;
  logic       sync, cmd_n, req_ready, done;
  logic       req_valid, req_src, req_chip;
  logic [1:0] req_reg;
  logic [3:0] req_char, req_op, req_wdata, rdata;

  ram_bus_master dut (
    .clock(clock), .reset(reset), .data(data), .sync(sync), .cmd_n(cmd_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_chip(req_chip), .req_reg(req_reg), .req_char(req_char),
    .req_op(req_op), .req_wdata(req_wdata), .done(done), .rdata(rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- RAM chip models, index = p0 strap ----------------
  logic [2:0] ram_cyc;
  logic [3:0] mem  [2][64];
  logic [3:0] stat [2][16];
  logic       sel [2];
  logic       act [2];
  logic [1:0] rl  [2];
  logic [3:0] cl  [2];
  logic [3:0] opl [2];
  logic       src_pend;
  logic       ram_oe;
  logic [3:0] ram_do;

  function automatic logic rd_op(input logic [3:0] op);
    return op == 4'h8 || op == 4'h9 || op == 4'hB;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      ram_cyc  <= 3'd0;
      src_pend <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        sel[p] <= 1'b0; act[p] <= 1'b0; rl[p] <= 2'd0; cl[p] <= 4'd0; opl[p] <= 4'd0;
        for (int i = 0; i < 64; i++) mem[p][i] <= 4'd0;
        for (int i = 0; i < 16; i++) stat[p][i] <= 4'd0;
      end
    end else begin
      ram_cyc  <= ram_cyc + 3'd1;
      src_pend <= !cmd_n && ram_cyc == 3'd6;
      for (int p = 0; p < 2; p++) begin
        if (!cmd_n && ram_cyc == 3'd6) begin
          sel[p] <= (data[2] == 1'(p));
          rl[p]  <= data[1:0];
        end
        if (src_pend && ram_cyc == 3'd7) cl[p] <= data;
        if (!cmd_n && ram_cyc == 3'd4) begin
          opl[p] <= data;
          act[p] <= sel[p];
        end
        if (act[p] && cmd_n && ram_cyc == 3'd6) begin
          if (opl[p] == 4'h0) mem[p][{rl[p], cl[p]}] <= data;
          else if (opl[p][3:2] == 2'b01) stat[p][{rl[p], opl[p][1:0]}] <= data;
        end
        if (ram_cyc == 3'd7) act[p] <= 1'b0;
      end
    end
  end

  always_comb begin
    ram_oe = 1'b0;
    ram_do = 4'd0;
    for (int p = 0; p < 2; p++) begin
      if (act[p] && ram_cyc == 3'd6 && rd_op(opl[p])) begin
        ram_oe = 1'b1;
        ram_do = mem[p][{rl[p], cl[p]}];
      end
    end
  end
  assign data = ram_oe ? ram_do : 4'bz;

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic [3:0] rd;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   tb_cyc = 0;
  int   last_done = 0;
  int   s4 = 0;
  int   s6 = 0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      tb_cyc++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("done_rdata", 32'(rdata), 32'(e.rd));
          if (e.gap != 0) chk("done_gap", 32'(tb_cyc - last_done), 32'(e.gap));
        end
        last_done = tb_cyc;
      end
      if (!reset) begin
        chk("sync", 32'(sync), 32'(ram_cyc == 3'd7));
        if (ram_cyc != 3'd7) chk("ready_off", 32'(req_ready), 32'(0));
        if (ram_cyc != 3'd4 && ram_cyc != 3'd6) chk("cmd_slot", 32'(cmd_n), 32'(1));
        if (ram_cyc < 3'd4 || ram_cyc == 3'd5) chk("bus_idle", 32'(data), 32'hF);
        if (ram_cyc == 3'd6 && !cmd_n) chk("src_bit3", 32'(data[3]), 32'(0));
        if (!cmd_n && ram_cyc == 3'd4) s4++;
        if (!cmd_n && ram_cyc == 3'd6) s6++;
      end
    end
  endtask

  task automatic issue(input logic src, input logic chip, input logic [1:0] rg,
                       input logic [3:0] ch, input logic [3:0] op, input logic [3:0] wd,
                       input logic [3:0] exp_rd, input int gap, input logic track);
    int   n = 0;
    exp_t e;
    req_src = src; req_chip = chip; req_reg = rg; req_char = ch;
    req_op = op; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(0), 32'(1));
      return;
    end
    @(posedge clock);
    if (track) begin
      e.rd = exp_rd;
      e.gap = gap;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int s4b, s6b;
    reset = 1'b1; req_valid = 1'b0; req_src = 1'b0; req_chip = 1'b0;
    req_reg = 2'd0; req_char = 4'd0; req_op = 4'd0; req_wdata = 4'd0;
    fork
      monitor();
    join_none

    // reset outputs
    @(negedge clock);
    chk("rst_cmd_n", 32'(cmd_n), 32'(1));
    chk("rst_bus", 32'(data), 32'hF);
    chk("rst_sync", 32'(sync), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    repeat (2) @(negedge clock);
    chk("rst_rdata", 32'(rdata), 32'(0));
    reset = 1'b0;

    // write chip0 reg2 char5 = A, then IO-only read of the same address
    issue(1'b1, 1'b0, 2'd2, 4'd5, 4'h0, 4'hA, 4'h0, 0, 1'b1);
    issue(1'b0, 1'b0, 2'd0, 4'd0, 4'h8, 4'h0, 4'hA, 0, 1'b1);
    req_valid = 1'b0;
    drain();
    chk("wr_mem0", 32'(mem[0][37]), 32'hA);
    chk("wr_mem1", 32'(mem[1][37]), 32'h0);

    // status write chip1 reg3 op6 = 9, with slot-by-slot bus checks
    s4b = s4; s6b = s6;
    issue(1'b1, 1'b1, 2'd3, 4'd0, 4'h6, 4'h9, 4'hA, 0, 1'b1);
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("src6_cmd", 32'(cmd_n), 32'(0));
    chk("src6_bus", 32'(data), 32'h7);
    @(negedge clock);
    chk("src7_cmd", 32'(cmd_n), 32'(1));
    chk("src7_bus", 32'(data), 32'h0);
    repeat (5) @(negedge clock);
    chk("io4_cmd", 32'(cmd_n), 32'(0));
    chk("io4_bus", 32'(data), 32'h6);
    repeat (2) @(negedge clock);
    chk("io6_cmd", 32'(cmd_n), 32'(1));
    chk("io6_bus", 32'(data), 32'h9);
    drain();
    chk("stat1", 32'(stat[1][14]), 32'h9);
    chk("stat0", 32'(stat[0][14]), 32'h0);
    chk("stat_s4", 32'(s4 - s4b), 32'(1));
    chk("stat_s6", 32'(s6 - s6b), 32'(1));

    // back-to-back: SRC+IO write, IO-only read (8 apart), SRC+IO read (16 apart)
    issue(1'b1, 1'b0, 2'd1, 4'd3, 4'h0, 4'h5, 4'hA, 0, 1'b1);
    issue(1'b0, 1'b0, 2'd0, 4'd0, 4'h8, 4'h0, 4'h5, 8, 1'b1);
    issue(1'b1, 1'b0, 2'd2, 4'd5, 4'h9, 4'h0, 4'hA, 16, 1'b1);
    req_valid = 1'b0;
    drain();
    chk("b2b_mem", 32'(mem[0][19]), 32'h5);

    // no-op opcode 3
    s4b = s4; s6b = s6;
    issue(1'b0, 1'b0, 2'd0, 4'd0, 4'h3, 4'h7, 4'hA, 0, 1'b1);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("nop4_cmd", 32'(cmd_n), 32'(0));
    chk("nop4_bus", 32'(data), 32'h3);
    repeat (2) @(negedge clock);
    chk("nop6_cmd", 32'(cmd_n), 32'(1));
    chk("nop6_bus", 32'(data), 32'hF);
    drain();
    chk("nop_s4", 32'(s4 - s4b), 32'(1));
    chk("nop_s6", 32'(s6 - s6b), 32'(0));
    chk("nop_mem_a", 32'(mem[0][37]), 32'hA);
    chk("nop_mem_b", 32'(mem[0][19]), 32'h5);
    chk("nop_rdata", 32'(rdata), 32'hA);

    // reset at SRC cycle 6 aborts the frame
    issue(1'b1, 1'b1, 2'd0, 4'd1, 4'h0, 4'h3, 4'h0, 0, 1'b0);
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("abort_pre_cmd", 32'(cmd_n), 32'(0));
    reset = 1'b1;
    @(negedge clock);
    chk("abort_cmd", 32'(cmd_n), 32'(1));
    chk("abort_bus", 32'(data), 32'hF);
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(0));
    chk("abort_rdata", 32'(rdata), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    issue(1'b1, 1'b1, 2'd0, 4'd1, 4'h0, 4'h3, 4'h0, 0, 1'b1);
    req_valid = 1'b0;
    drain();
    chk("post_mem1", 32'(mem[1][1]), 32'h3);
    chk("post_mem0", 32'(mem[0][1]), 32'h0);

    repeat (10) @(negedge clock);
    chk("final_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 Parameters: none; frame length is fixed at 8 clocks.
REQ-002 clock  input  1  system clock; all state changes on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 data  inout  4  shared RAM bus; driven only in the slots listed below, otherwise high-Z.
REQ-005 sync  output  1  frame marker; high while cycle==7.
REQ-006 cmd_n  output  1  active-low command strobe to RAM chips.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted on a posedge where req_valid && req_ready.
REQ-009 req_src  input  1  1 = issue SRC frame before the I/O frame; 0 = I/O frame only, reusing the last address.
REQ-010 req_chip  input  1  chip select bit, compared by RAM against its p0 strap.
REQ-011 req_reg  input  2  register address within the chip.
REQ-012 req_char  input  4  character address within the register.
REQ-013 req_op  input  4  I/O opcode: 0 WRM, 4-7 WRS0-3, 8/9/B reads, others no-op.
REQ-014 req_wdata  input  4  write data for opcodes 0 and 4-7.
REQ-015 done  output  1  one-clock pulse when an I/O frame completes.
REQ-016 rdata  output  4  data sampled by the last read opcode; held until the next read.

Function
REQ-017 Free-running 3-bit counter cycle: 0 out of reset, +1 per clock, wraps 7->0; matches the RAM counter, which resets on the same reset.
REQ-018 FSM states: IDLE, SRC, IO.
REQ-019 req_ready = (state==IDLE || state==IO) && cycle==7; not asserted at any other time.
REQ-020 On accept, all request fields are captured into registers; req_* inputs are ignored afterwards until the next accept.
REQ-021 On accept, the FSM goes to SRC if req_src=1, otherwise to IO; the new frame spans cycles 0-7.
REQ-022 SRC frame, cycle 6: cmd_n=0; data={1'b0, chip, reg[1:0]}.
REQ-023 SRC frame, cycle 7: cmd_n=1; data=char.
REQ-024 SRC frame, all other cycles: cmd_n=1; data high-Z.
REQ-025 SRC frame exit: at the posedge with cycle==7, the FSM goes to IO.
REQ-026 IO frame, cycle 4: cmd_n=0; data=op.
REQ-027 IO frame, cycle 6, opcode 0 or 4-7: cmd_n=1; data=wdata.
REQ-028 IO frame, cycle 6, opcode 8, 9 or B: data high-Z; rdata loads data at the posedge with cycle==6.
REQ-029 IO frame, cycle 6, other opcodes: data high-Z; rdata unchanged.
REQ-030 IO frame, cycles other than 4 and 6: cmd_n=1; data high-Z.
REQ-031 cmd_n is never low at cycle 6 of an IO frame or at cycle 4 of an SRC frame; this prevents false SRC decode or instruction latch in the RAM.
REQ-032 IO frame exit, at the posedge with cycle==7: if a new request is accepted, the FSM goes to SRC or IO per REQ-021; otherwise it goes to IDLE.
REQ-033 done is registered: it is high for exactly the clock following the posedge where an IO frame ends (cycle==0).
REQ-034 Back-to-back: the next request may be accepted at the last cycle of the current IO frame with no gap frame; done still pulses.
REQ-035 IDLE: cmd_n=1; data high-Z; the counter keeps running.
REQ-036 The bus is never driven in the same cycle that a read slot is released; the master drives only in the slots defined in REQ-022, 023, 026 and 027.

Reset
REQ-037 On a posedge with reset=1: cycle=0, state=IDLE, done=0, rdata=0, captured request fields=0.
REQ-038 Outputs under reset: cmd_n=1, data high-Z, sync=0, req_ready=0 from the first clock edge with reset high.
REQ-039 Reset asserted mid-frame aborts the frame: no done pulse; the bus is released on the next edge.

Verification
REQ-040 Bench: this block plus two RAM instances with p0=0 and p0=1; all bus activity is checked against the cycle-level rules above.
REQ-041 Write/read: req_src=1, chip0 reg2 char5, op=0, wdata=A; then req_src=0, op=8 -> done twice; rdata=A; RAM p0=1 does not change.
REQ-042 Status write: chip1 reg3, op=6, wdata=9 -> only RAM p0=1 status[3*4+2]=9; cmd_n low only at SRC cycle 6 and IO cycle 4.
REQ-043 Back-to-back: req_valid held high with 3 queued requests -> accepts at consecutive frame boundaries; done pulses 16 clocks apart for SRC+IO requests and 8 apart for IO-only.
REQ-044 No-op opcode 3 -> cmd_n pulse at cycle 4, bus high-Z at cycle 6, done=1, rdata unchanged, RAM contents unchanged.
REQ-045 Reset asserted at SRC cycle 6 -> next edge: cmd_n=1, data=Z, state IDLE, no done; a fresh request after reset completes normally.
